// File: rtl/mipi_frame_writer_pkg.sv
// mipi_frame_writer_pkg: shared state type and bus widths for the MIPI frame writer
package mipi_frame_writer_pkg;
    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, FLUSH, DONE} state_e;
    localparam int PIX_W      = 10;
    localparam int AVM_DATA_W = 16;
    localparam int AVM_ADDR_W = 32;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead single-clock FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] cnt_t;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == cnt_t'(DEPTH);
    assign empty   = count == '0;
    // full/empty gate on the pre-pop count, so a push into a full FIFO drops even if a pop coincides
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
        end
    end
endmodule

// File: rtl/mipi_frame_writer.sv
// mipi_frame_writer: captures one MIPI pixel frame and burst-writes it to SDRAM over Avalon-MM
module mipi_frame_writer
    import mipi_frame_writer_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [AVM_ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]      frame_words,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [CNT_W-1:0]      words_written,
    input  logic                  pix_valid,
    input  logic [PIX_W-1:0]      pix_data,
    input  logic                  pix_hs,
    input  logic                  pix_vs,
    output logic [AVM_ADDR_W-1:0] avm_address,
    output logic [4:0]            avm_burstcount,
    output logic                  avm_write,
    output logic [AVM_DATA_W-1:0] avm_writedata,
    input  logic                  avm_waitrequest
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    typedef logic [CW-1:0] cnt_t;
    state_e state;
    logic vs_q, push_v, fifo_full, fifo_empty, acc, beat, burst_go, vs_fall, last_pix;
    logic [PIX_W-1:0] push_d, fifo_rdata;
    cnt_t fifo_count;
    logic [4:0] beats_left, burst_len;
    logic [CNT_W-1:0] fw, cap_cnt;
    logic [AVM_ADDR_W-1:0] cur_addr;

    sync_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(push_v),
        .wdata(push_d),
        .pop(beat),
        .rdata(fifo_rdata),
        .count(fifo_count),
        .full(fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        acc           = state == CAPTURE && pix_valid && pix_hs && pix_vs;
        vs_fall       = vs_q && !pix_vs;
        last_pix      = acc && cap_cnt + CNT_W'(1) == fw;
        beat          = avm_write && !avm_waitrequest;
        burst_len     = fifo_count >= cnt_t'(BURST_LEN) ? 5'(BURST_LEN) : 5'(fifo_count);
        // a short tail burst waits for the in-flight pixel so the frame ends in one partial burst
        burst_go      = !avm_write && (state == CAPTURE || state == FLUSH) &&
                        (fifo_count >= cnt_t'(BURST_LEN) || (state == FLUSH && !push_v && !fifo_empty));
        avm_writedata = avm_write ? AVM_DATA_W'(fifo_rdata) : '0;
        done          = state == DONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            vs_q           <= 1'b0;
            push_v         <= 1'b0;
            push_d         <= '0;
            busy           <= 1'b0;
            overflow       <= 1'b0;
            words_written  <= '0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            avm_write      <= 1'b0;
            beats_left     <= '0;
            fw             <= '0;
            cap_cnt        <= '0;
            cur_addr       <= '0;
        end else begin
            vs_q   <= pix_vs;
            push_v <= acc;
            push_d <= pix_data;
            if (push_v && fifo_full) overflow <= 1'b1;
            if (beat) words_written <= words_written + CNT_W'(1);
            if (burst_go) begin
                avm_address    <= cur_addr;
                avm_burstcount <= burst_len;
                beats_left     <= burst_len;
                avm_write      <= 1'b1;
                cur_addr       <= cur_addr + AVM_ADDR_W'({burst_len, 1'b0});
            end else if (beat) begin
                beats_left <= beats_left - 5'd1;
                if (beats_left == 5'd1) avm_write <= 1'b0;
            end
            case (state)
                IDLE: if (start) begin
                    fw            <= frame_words;
                    cur_addr      <= base_addr;
                    cap_cnt       <= '0;
                    overflow      <= 1'b0;
                    words_written <= '0;
                    busy          <= 1'b1;
                    state         <= frame_words == '0 ? DONE : ARM;
                end
                ARM: if (!vs_q && pix_vs) state <= CAPTURE;
                CAPTURE: begin
                    // dropped pixels still count so the frame geometry stays intact
                    if (acc) cap_cnt <= cap_cnt + CNT_W'(1);
                    if (last_pix || vs_fall) state <= FLUSH;
                end
                FLUSH: if (fifo_empty && !avm_write && !push_v) state <= DONE;
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mipi_frame_writer.sv
// tb_mipi_frame_writer: randomized scoreboard bench for mipi_frame_writer
module tb_mipi_frame_writer;
    localparam int BL    = 8;
    localparam int DEPTH = 32;
    localparam int CNT_W = 24;

    logic clk = 1'b0;
    logic reset_n, start, busy, done, overflow, pix_valid, pix_hs, pix_vs, avm_write, avm_waitrequest;
    logic [31:0] base_addr, avm_address;
    logic [CNT_W-1:0] frame_words, words_written;
    logic [9:0] pix_data;
    logic [4:0] avm_burstcount;
    logic [15:0] avm_writedata;

    typedef struct packed {logic [31:0] a; logic [4:0] bc; logic [15:0] d;} beat_t;
    beat_t sb[$];
    int checks = 0, failures = 0, beats_seen = 0, done_cnt = 0, cyc = 0, stall_end = 0, mode = 0;

    always #5 clk = ~clk;

    mipi_frame_writer #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .base_addr(base_addr),
        .frame_words(frame_words),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .words_written(words_written),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_hs(pix_hs),
        .pix_vs(pix_vs),
        .avm_address(avm_address),
        .avm_burstcount(avm_burstcount),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every accepted beat is popped against the scoreboard; stalled beats must hold
    logic stall_q = 1'b0;
    beat_t held, cur, exp_b;
    always @(negedge clk) begin
        cur = {avm_address, avm_burstcount, avm_writedata};
        if (!reset_n) stall_q = 1'b0;
        else if (avm_write) begin
            if (stall_q) check("stall_hold", 64'(cur), 64'(held));
            if (avm_waitrequest) begin
                stall_q = 1'b1;
                held = cur;
            end else begin
                stall_q = 1'b0;
                beats_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", cur);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat", 64'(cur), 64'(exp_b));
                end
            end
        end else stall_q = 1'b0;
        if (reset_n && done) done_cnt++;
    end

    // slave stall model: 0 none, 1 three stall cycles per beat, 2 stall until stall_end
    initial begin
        int sc = 0;
        avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mode == 0) avm_waitrequest = 1'b0;
            else if (mode == 1) begin
                if (avm_write && sc == 3) begin
                    avm_waitrequest = 1'b0;
                    sc = 0;
                end else begin
                    avm_waitrequest = 1'b1;
                    sc = avm_write ? sc + 1 : 0;
                end
            end else avm_waitrequest = cyc < stall_end;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [31:0] b, input int w);
        base_addr = b;
        frame_words = CNT_W'(w);
        start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = $urandom;
        frame_words = CNT_W'($urandom);
    endtask

    // expected beat i of a frame of len stored words: full bursts first, then one tail burst
    task automatic expect_beat(input logic [31:0] b, input int i, input int len, input logic [9:0] d);
        beat_t e;
        int k = (i / BL) * BL;
        e.a = b + 32'(2 * k);
        e.bc = 5'((len - k < BL) ? len - k : BL);
        e.d = {6'b0, d};
        sb.push_back(e);
    endtask

    task automatic frame(input logic [31:0] b, input int n, input int len, input int gap_pct,
                         input bit seq, input int spur_at);
        pix_vs = 1'b1;
        tick(2);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                pix_valid = 1'($urandom_range(1));
                pix_hs = 1'b0;
                pix_data = 10'($urandom);
                tick();
            end
            pix_valid = 1'b1;
            pix_hs = 1'b1;
            pix_data = seq ? 10'(i) : 10'($urandom);
            if (i < len) expect_beat(b, i, len, pix_data);
            if (i == spur_at) begin
                start = 1'b1;
                base_addr = 32'hDEAD_0000;
                frame_words = 5;
            end
            tick();
            start = 1'b0;
        end
        pix_valid = 1'b0;
        pix_hs = 1'b0;
        tick(3);
        pix_vs = 1'b0;
        tick(2);
    endtask

    task automatic finish_frame(input string tag, input int d0, input int len, input bit ovf);
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin
            tick();
            t++;
        end
        tick(2);
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_words"}, words_written, len);
        check({tag, "_ovf"}, overflow, ovf);
        check({tag, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        int d0, b0, t, n, fw, len;
        logic [31:0] base;
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        frame_words = '0;
        pix_valid = 1'b0;
        pix_hs = 1'b0;
        pix_vs = 1'b0;
        pix_data = '0;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_write", avm_write, 0);
        check("rst_addr", avm_address, 0);
        check("rst_bc", avm_burstcount, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_words", words_written, 0);
        reset_n = 1'b1;
        tick(2);

        d0 = done_cnt;
        do_start(32'h1000, 16);
        check("arm_busy", busy, 1);
        frame(32'h1000, 16, 16, 0, 1'b1, -1);
        finish_frame("seq16", d0, 16, 1'b0);

        d0 = done_cnt;
        do_start(32'h2000, 20);
        frame(32'h2000, 13, 13, 20, 1'b0, -1);
        finish_frame("vsfall", d0, 13, 1'b0);

        mode = 1;
        d0 = done_cnt;
        do_start(32'h3000, 24);
        frame(32'h3000, 24, 24, 30, 1'b0, -1);
        finish_frame("stall3", d0, 24, 1'b0);

        mode = 2;
        stall_end = cyc + 100;
        d0 = done_cnt;
        do_start(32'h4000, 40);
        frame(32'h4000, 50, DEPTH, 0, 1'b0, -1);
        finish_frame("ovf", d0, DEPTH, 1'b1);
        mode = 0;

        pix_vs = 1'b1;
        pix_valid = 1'b1;
        pix_hs = 1'b1;
        tick(3);
        d0 = done_cnt;
        do_start(32'h5000, 8);
        tick(4);
        pix_valid = 1'b0;
        pix_vs = 1'b0;
        tick(2);
        check("vs_high_wait_busy", busy, 1);
        check("vs_high_wait_words", words_written, 0);
        frame(32'h5000, 8, 8, 10, 1'b0, 3);
        finish_frame("vswait", d0, 8, 1'b0);

        d0 = done_cnt;
        do_start(32'h6000, 0);
        tick();
        check("zero_done", 64'(done_cnt - d0), 64'd1);
        check("zero_busy", busy, 0);
        check("zero_words", words_written, 0);

        mode = 2;
        stall_end = cyc + 100000;
        do_start(32'h7000, 16);
        frame(32'h7000, 16, 16, 0, 1'b0, -1);
        stall_end = cyc;
        b0 = beats_seen;
        t = 0;
        while (beats_seen - b0 < 3 && t < 100) begin
            tick();
            t++;
        end
        check("rst_mid_beats", beats_seen - b0, 3);
        reset_n = 1'b0;
        #1;
        check("rst_mid_write", avm_write, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_words", words_written, 0);
        sb.delete();
        mode = 0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        d0 = done_cnt;
        do_start(32'h7100, 16);
        frame(32'h7100, 16, 16, 15, 1'b0, -1);
        finish_frame("post_rst", d0, 16, 1'b0);

        for (int it = 0; it < 4; it++) begin
            fw = $urandom_range(40, 1);
            n = $urandom_range(50, 1);
            len = n < fw ? n : fw;
            base = it == 0 ? 32'hFFFF_FFF0 : $urandom;
            d0 = done_cnt;
            do_start(base, fw);
            frame(base, n, len, $urandom_range(40, 0), 1'b0, -1);
            finish_frame("rand", d0, len, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
